// File: rtl/hazard_if.sv
// Hazard-controller bundle: the pipeline (master) reports ID/EX/MEM/WB
// status; the controller (slave) returns per-stage stall/flush controls.
interface hazard_if #(
    parameter int GR_W = 5
);
    logic [GR_W-1:0] rj_no_id;
    logic [GR_W-1:0] rk_no_id;
    logic            rj_used_id;
    logic            rk_used_id;
    logic [GR_W-1:0] rd_no_ex;
    logic            memRead_ex;
    logic            div_start_ex;
    logic            branch_taken_ex;
    logic            dmem_req_mem;
    logic            dmem_ok_mem;
    logic            excp_wb;

    logic            stall_if;
    logic            stall_id;
    logic            stall_ex;
    logic            stall_mem;
    logic            flush_id;
    logic            flush_ex;
    logic            flush_mem;
    logic            flush_wb;
    logic            div_busy;
    logic            div_done;

    modport master (
        output rj_no_id, rk_no_id, rj_used_id, rk_used_id, rd_no_ex,
               memRead_ex, div_start_ex, branch_taken_ex,
               dmem_req_mem, dmem_ok_mem, excp_wb,
        input  stall_if, stall_id, stall_ex, stall_mem,
               flush_id, flush_ex, flush_mem, flush_wb,
               div_busy, div_done
    );

    modport slave (
        input  rj_no_id, rk_no_id, rj_used_id, rk_used_id, rd_no_ex,
               memRead_ex, div_start_ex, branch_taken_ex,
               dmem_req_mem, dmem_ok_mem, excp_wb,
        output stall_if, stall_id, stall_ex, stall_mem,
               flush_id, flush_ex, flush_mem, flush_wb,
               div_busy, div_done
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller for the 5-stage core. Resolves the
// hazards forwarding cannot: load-use, divider occupancy, data-memory wait,
// taken-branch redirect and WB exception flush.
// Priority: exception > memory wait > divide > branch > load-use.
module hazard_ctrl #(
    parameter int GR_W       = 5,
    parameter int DIV_CYCLES = 33
) (
    input  logic     clk,
    input  logic     rst,
    hazard_if.slave  hz
);
    localparam int CNT_W = $clog2(DIV_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIV_BUSY = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t           state, next_state;
    logic [CNT_W-1:0] div_cnt, next_cnt;
    logic             mem_stall;
    logic             load_use;

    // Memory wait: a fresh unanswered request, or a tracked wait still pending.
    // In DIV_BUSY only the fresh-request term applies (the wait is not tracked
    // in state there), which is what the first term already gives.
    assign mem_stall = !hz.dmem_ok_mem
                     & (hz.dmem_req_mem | (state == MEM_WAIT));

    // Load in EX feeding a source operand of ID; r0 is hardwired and never stalls.
    assign load_use = hz.memRead_ex & (hz.rd_no_ex != {GR_W{1'b0}})
                    & ((hz.rj_used_id & (hz.rj_no_id == hz.rd_no_ex))
                     | (hz.rk_used_id & (hz.rk_no_id == hz.rd_no_ex)));

    // State register and divide countdown.
    // NOTE: only the control state is reset here; the outputs are combinational
    // and are forced low by rst directly in the decode below.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            div_cnt <= '0;
        end else begin
            // NOTE: non-blocking in clocked blocks so every register samples
            // pre-edge values; the combinational block below uses blocking.
            state   <= next_state;
            div_cnt <= next_cnt;
        end
    end

    // Prioritised next-state and stall/flush decode.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        next_state   = state;
        next_cnt     = div_cnt;
        hz.stall_if  = 1'b0;
        hz.stall_id  = 1'b0;
        hz.stall_ex  = 1'b0;
        hz.stall_mem = 1'b0;
        hz.flush_id  = 1'b0;
        hz.flush_ex  = 1'b0;
        hz.flush_mem = 1'b0;
        hz.flush_wb  = 1'b0;
        hz.div_busy  = 1'b0;
        hz.div_done  = 1'b0;

        if (!rst) begin
            hz.div_busy = (state == DIV_BUSY);

            if (hz.excp_wb) begin
                // Exception squashes everything in flight and aborts waits.
                hz.flush_id  = 1'b1;
                hz.flush_ex  = 1'b1;
                hz.flush_mem = 1'b1;
                hz.flush_wb  = 1'b1;
                next_state   = IDLE;
                next_cnt     = '0;
            end else if (mem_stall) begin
                // Freeze IF..MEM, bubble into WB; divider count is frozen too.
                hz.stall_if  = 1'b1;
                hz.stall_id  = 1'b1;
                hz.stall_ex  = 1'b1;
                hz.stall_mem = 1'b1;
                hz.flush_wb  = 1'b1;
                if (state == IDLE) begin
                    next_state = MEM_WAIT;
                end
            end else if (state == DIV_BUSY) begin
                if (div_cnt == CNT_W'(1)) begin
                    // Last occupancy cycle: result valid, EX advances.
                    hz.div_done = 1'b1;
                    next_state  = IDLE;
                    next_cnt    = '0;
                end else begin
                    hz.stall_if  = 1'b1;
                    hz.stall_id  = 1'b1;
                    hz.stall_ex  = 1'b1;
                    hz.flush_mem = 1'b1;
                    next_cnt     = div_cnt - CNT_W'(1);
                end
            end else begin
                // IDLE, or MEM_WAIT in the cycle the response arrives: the
                // pipeline releases and the lower-priority hazards apply now.
                next_state = IDLE;
                if (hz.div_start_ex) begin
                    hz.stall_if  = 1'b1;
                    hz.stall_id  = 1'b1;
                    hz.stall_ex  = 1'b1;
                    hz.flush_mem = 1'b1;
                    next_state   = DIV_BUSY;
                    next_cnt     = CNT_W'(DIV_CYCLES - 1);
                end else if (hz.branch_taken_ex) begin
                    // ID holds a wrong-path instruction, so this beats load-use.
                    hz.flush_id = 1'b1;
                    hz.flush_ex = 1'b1;
                end else if (load_use) begin
                    hz.stall_if = 1'b1;
                    hz.stall_id = 1'b1;
                    hz.flush_ex = 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed hazard scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_hazard_ctrl;
    localparam int GR_W       = 5;
    localparam int DIV_CYCLES = 33;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_if #(.GR_W(GR_W)) hz ();

    hazard_ctrl #(.GR_W(GR_W), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.slave)
    );

    typedef struct packed {
        logic            rj_used;
        logic            rk_used;
        logic            mem_read;
        logic            div_start;
        logic            branch;
        logic            req;
        logic            ok;
        logic            excp;
        logic [GR_W-1:0] rj;
        logic [GR_W-1:0] rk;
        logic [GR_W-1:0] rd;
    } stim_t;

    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic stall_ex;
        logic stall_mem;
        logic flush_id;
        logic flush_ex;
        logic flush_mem;
        logic flush_wb;
        logic div_busy;
        logic div_done;
    } obs_t;

    int checks   = 0;
    int failures = 0;

    // Reference model state: EX cycles still owed to an active divide, and
    // whether an unanswered memory request is being waited on.
    int div_left    = 0;
    bit mem_waiting = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic obs_t observe();
        obs_t o;
        o.stall_if  = hz.stall_if;
        o.stall_id  = hz.stall_id;
        o.stall_ex  = hz.stall_ex;
        o.stall_mem = hz.stall_mem;
        o.flush_id  = hz.flush_id;
        o.flush_ex  = hz.flush_ex;
        o.flush_mem = hz.flush_mem;
        o.flush_wb  = hz.flush_wb;
        o.div_busy  = hz.div_busy;
        o.div_done  = hz.div_done;
        return o;
    endfunction

    task automatic apply(input stim_t s);
        hz.rj_no_id        = s.rj;
        hz.rk_no_id        = s.rk;
        hz.rj_used_id      = s.rj_used;
        hz.rk_used_id      = s.rk_used;
        hz.rd_no_ex        = s.rd;
        hz.memRead_ex      = s.mem_read;
        hz.div_start_ex    = s.div_start;
        hz.branch_taken_ex = s.branch;
        hz.dmem_req_mem    = s.req;
        hz.dmem_ok_mem     = s.ok;
        hz.excp_wb         = s.excp;
    endtask

    // One cycle of the controller as described by its priority rules.
    task automatic model_step(input stim_t s, output obs_t e);
        bit lu;
        bit ms;
        e  = '0;
        lu = s.mem_read && (s.rd != 0)
          && ((s.rj_used && s.rj == s.rd) || (s.rk_used && s.rk == s.rd));
        ms = !s.ok && (s.req || mem_waiting);
        e.div_busy = (div_left > 0);
        if (s.excp) begin
            e.flush_id = 1; e.flush_ex = 1; e.flush_mem = 1; e.flush_wb = 1;
            div_left    = 0;
            mem_waiting = 0;
        end else if (ms) begin
            e.stall_if = 1; e.stall_id = 1; e.stall_ex = 1; e.stall_mem = 1;
            e.flush_wb = 1;
            if (div_left == 0) mem_waiting = 1;
        end else if (div_left > 0) begin
            if (div_left == 1) begin
                e.div_done = 1;
                div_left   = 0;
            end else begin
                e.stall_if = 1; e.stall_id = 1; e.stall_ex = 1; e.flush_mem = 1;
                div_left--;
            end
        end else begin
            mem_waiting = 0;
            if (s.div_start) begin
                e.stall_if = 1; e.stall_id = 1; e.stall_ex = 1; e.flush_mem = 1;
                div_left = DIV_CYCLES - 1;
            end else if (s.branch) begin
                e.flush_id = 1; e.flush_ex = 1;
            end else if (lu) begin
                e.stall_if = 1; e.stall_id = 1; e.flush_ex = 1;
            end
        end
    endtask

    // Drive one cycle's inputs mid-period, compare, and let the edge pass.
    task automatic step(input string tag, input stim_t s, output obs_t o);
        obs_t e;
        @(negedge clk);
        apply(s);
        #1;
        model_step(s, e);
        o = observe();
        check(tag, 32'(o), 32'(e));
    endtask

    initial begin
        stim_t s;
        obs_t  o;
        int    busy_cnt, stall_ex_cnt, done_at, stall_mem_cnt, flush_id_cnt;

        // Reset: outputs held low even with exception/request inputs active.
        rst = 1'b1;
        s = '0; s.excp = 1; s.req = 1;
        apply(s);
        #2;
        check("reset_excp", 32'(observe()), 32'(0));
        s = '0; s.div_start = 1;
        apply(s);
        #1;
        check("reset_div", 32'(observe()), 32'(0));
        @(negedge clk);
        s = '0;
        apply(s);
        rst = 1'b0;

        step("idle", s, o);

        // Load-use on rj, then release.
        s = '0; s.mem_read = 1; s.rd = 5; s.rj = 5; s.rj_used = 1;
        step("loaduse_rj", s, o);
        s = '0;
        step("loaduse_after", s, o);
        // Load-use on rk.
        s = '0; s.mem_read = 1; s.rd = 9; s.rk = 9; s.rk_used = 1; s.rj = 9;
        step("loaduse_rk", s, o);
        // r0 never stalls.
        s = '0; s.mem_read = 1; s.rd = 0; s.rj = 0; s.rj_used = 1;
        step("loaduse_r0", s, o);
        // Matching register but operand not read.
        s = '0; s.mem_read = 1; s.rd = 3; s.rk = 3; s.rk_used = 0;
        step("loaduse_unused", s, o);

        // Divide: occupancy window and done timing.
        busy_cnt = 0; stall_ex_cnt = 0; done_at = -1;
        s = '0; s.div_start = 1;
        for (int k = 0; k < DIV_CYCLES; k++) begin
            step("div_run", s, o);
            busy_cnt     += int'(o.div_busy);
            stall_ex_cnt += int'(o.stall_ex);
            if (o.div_done) done_at = k;
        end
        s = '0;
        step("div_idle", s, o);
        check("div_busy_cycles", 32'(busy_cnt), 32'(DIV_CYCLES - 1));
        check("div_stall_ex_cycles", 32'(stall_ex_cnt), 32'(DIV_CYCLES - 1));
        check("div_done_cycle", 32'(done_at), 32'(DIV_CYCLES - 1));

        // Memory wait of 4 cycles, released in the ok cycle.
        stall_mem_cnt = 0;
        s = '0; s.req = 1;
        for (int k = 0; k < 4; k++) begin
            step("mem_wait", s, o);
            stall_mem_cnt += int'(o.stall_mem);
        end
        s.ok = 1;
        step("mem_ok", s, o);
        stall_mem_cnt += int'(o.stall_mem);
        check("mem_stall_cycles", 32'(stall_mem_cnt), 32'(4));
        s = '0; s.req = 1; s.ok = 1;
        step("mem_req_ok_same", s, o);

        // Branch held across a memory wait: one flush in the ok cycle.
        flush_id_cnt = 0;
        s = '0; s.req = 1; s.branch = 1;
        for (int k = 0; k < 3; k++) begin
            step("br_memwait", s, o);
            flush_id_cnt += int'(o.flush_id);
        end
        s.ok = 1;
        step("br_mem_ok", s, o);
        flush_id_cnt += int'(o.flush_id);
        check("br_flush_cycles", 32'(flush_id_cnt), 32'(1));
        s = '0;
        step("br_after", s, o);

        // Branch overrides a simultaneous load-use.
        s = '0; s.branch = 1; s.mem_read = 1; s.rd = 7; s.rj = 7; s.rj_used = 1;
        step("br_over_loaduse", s, o);

        // Exception at div_cnt=10 aborts the divide.
        s = '0; s.div_start = 1;
        step("excp_div_start", s, o);
        for (int k = 0; k < DIV_CYCLES - 11; k++) step("excp_div_run", s, o);
        s.excp = 1;
        step("excp_abort", s, o);
        check("excp_flushes", 32'(o), 32'(10'b0000111110));
        s = '0;
        step("excp_after", s, o);

        // Asynchronous reset mid-divide.
        s = '0; s.div_start = 1;
        for (int k = 0; k < 6; k++) step("rst_div_run", s, o);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", 32'(observe()), 32'(0));
        div_left    = 0;
        mem_waiting = 0;
        @(negedge clk);
        s = '0;
        apply(s);
        rst = 1'b0;
        step("rst_after", s, o);

        // Randomized traffic.
        for (int k = 0; k < 800; k++) begin
            s = '0;
            s.rj        = GR_W'($urandom_range(0, 3));
            s.rk        = GR_W'($urandom_range(0, 3));
            s.rd        = GR_W'($urandom_range(0, 3));
            s.rj_used   = 1'($urandom_range(0, 1));
            s.rk_used   = 1'($urandom_range(0, 1));
            s.mem_read  = ($urandom_range(0, 2) == 0);
            s.div_start = ($urandom_range(0, 15) == 0);
            s.branch    = !s.div_start && ($urandom_range(0, 5) == 0);
            s.req       = ($urandom_range(0, 3) == 0);
            s.ok        = 1'($urandom_range(0, 1));
            s.excp      = ($urandom_range(0, 39) == 0);
            step("random", s, o);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
